// File: rtl/irq_ctrl.sv
// Interrupt front-end: edge-latching pending register, enable mask, lowest-index grant
// and a one-hot hardInterrupt handshake with acknowledge timeout. Define IRQ_SYNC_EN for async irqIn pins.
module irq_ctrl #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rstIn,
    input  logic [3:0] irqIn,
    input  logic       maskWe,
    input  logic [3:0] maskIn,
    input  logic       intAck,
    input  logic       clrFlags,
    output logic [3:0] hardInterrupt,
    output logic [3:0] pending,
    output logic [3:0] overrun,
    output logic       timeoutFlag,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        GAP
    } StateT;

    localparam logic [7:0] TIMEOUT_VAL = 8'(ACK_TIMEOUT);

    StateT      state;
    logic [3:0] syncOut;
    logic [3:0] prevIrq;
    logic [3:0] mask;
    logic [1:0] grant;
    logic [7:0] tmoCount;

    logic [3:0] rise;
    logic [3:0] eligible;
    logic [1:0] lowIdx;
    logic [3:0] clearBits;
    logic [3:0] newOverrun;
    logic       ackHit;
    logic       timeoutHit;

`ifdef IRQ_SYNC_EN
    logic [3:0] sync1;
    logic [3:0] sync2;

    always_ff @(posedge clk) begin
        if (!rstIn) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irqIn;
            sync2 <= sync1;
        end
    end

    assign syncOut = sync2;
`else
    assign syncOut = irqIn;
`endif

    always_ff @(posedge clk) begin
        if (!rstIn) begin
            prevIrq <= '0;
        end else begin
            prevIrq <= syncOut;
        end
    end

    // An acknowledge only clears the granted bit; a same-cycle edge on that line re-sets it.
    always_comb begin
        rise       = syncOut & ~prevIrq;
        eligible   = pending & mask;
        lowIdx     = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (eligible[i]) begin
                lowIdx = 2'(i);
            end
        end
        ackHit     = (state == ASSERT) && intAck;
        timeoutHit = (state == ASSERT) && !intAck && (tmoCount == TIMEOUT_VAL);
        clearBits  = ackHit ? (4'b0001 << grant) : 4'b0000;
        newOverrun = rise & pending & ~clearBits;
    end

    always_ff @(posedge clk) begin
        if (!rstIn) begin
            pending     <= '0;
            overrun     <= '0;
            timeoutFlag <= 1'b0;
            mask        <= '0;
        end else begin
            pending     <= (pending & ~clearBits) | rise;
            overrun     <= (clrFlags ? 4'b0000 : overrun) | newOverrun;
            timeoutFlag <= (clrFlags ? 1'b0 : timeoutFlag) | timeoutHit;
            if (maskWe) begin
                mask <= maskIn;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstIn) begin
            state         <= IDLE;
            grant         <= 2'd0;
            tmoCount      <= 8'd0;
            hardInterrupt <= 4'b0000;
            busy          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (eligible != 4'b0000) begin
                        grant         <= lowIdx;
                        tmoCount      <= 8'd0;
                        hardInterrupt <= 4'b0001 << lowIdx;
                        busy          <= 1'b1;
                        state         <= ASSERT;
                    end
                end
                ASSERT: begin
                    if (intAck || timeoutHit) begin
                        hardInterrupt <= 4'b0000;
                        state         <= GAP;
                    end else begin
                        tmoCount <= tmoCount + 8'd1;
                    end
                end
                GAP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    hardInterrupt <= 4'b0000;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule
